// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wb_arb_pkg;

    localparam int DEF_CNT_W   = 4;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    // Per-master response bundle built from the slave side and the grant.
    typedef struct packed {
        logic ack;
        logic err;
        logic stall;
    } wb_rsp_t;

    // Index of the master that wins a simultaneous request: the one not served last.
    function automatic logic tie_winner(input logic last);
        return ~last;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Hung-cycle detector: counts busy cycles without an ack and fires on the terminal count.
// Latency: fire is combinational in the TIMEOUT-th consecutive busy, ack-less cycle.
// Backpressure: none; clears itself on fire, on any ack, when idle, or on clr.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic busy,
    input  logic ack,
    input  logic clr,
    output logic fire
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd;

    assign fire = busy & ~ack & (wd == WD_LAST);

    // Count consecutive cycles that have transfers in flight but see no ack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd <= '0;
        end else if (clr || fire || ack || !busy) begin
            wd <= '0;
        end else begin
            wd <= wd + WD_W'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave pipelined Wishbone arbiter: round-robin grant, cycle lock, watchdog.
// Latency: grant one edge after cyc rises in IDLE; stb/ack/data/stall pass through combinationally.
// Backpressure: non-owner always stalled; owner stalled by slave stall or a full outstanding count.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic        o_m0_stall,
    output logic [31:0] o_m0_data,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_m1_stall,
    output logic [31:0] o_m1_data,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_data,
    input  logic        i_s_ack,
    input  logic        i_s_stall,
    input  logic [31:0] i_s_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_t       state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] count, count_nxt;

    logic        own_cyc, own_stb, own_we;
    logic [31:0] own_addr, own_data;
    logic        grant0, grant1;
    logic        sat, fire, abort;
    logic        s_take, ack_take;
    logic        wd_busy, wd_clr;
    wb_rsp_t     rsp0, rsp1;

    assign grant0 = (state == ARB_GNT0);
    assign grant1 = (state == ARB_GNT1);
    assign sat    = (count == CNT_MAX);

    // Select the owning master's request; everything reads as zero while idle.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_addr = 32'h0;
        own_data = 32'h0;
        case (state)
            ARB_GNT0: begin
                own_cyc  = i_m0_cyc;
                own_stb  = i_m0_stb;
                own_we   = i_m0_we;
                own_addr = i_m0_addr;
                own_data = i_m0_data;
            end
            ARB_GNT1: begin
                own_cyc  = i_m1_cyc;
                own_stb  = i_m1_stb;
                own_we   = i_m1_we;
                own_addr = i_m1_addr;
                own_data = i_m1_data;
            end
            default: ;
        endcase
    end

    // The watchdog pulse kills the slave cycle in the same clock it fires.
    assign o_s_cyc  = own_cyc & ~fire;
    assign o_s_stb  = own_cyc & own_stb & ~sat & ~fire;
    assign o_s_we   = own_we;
    assign o_s_addr = own_addr;
    assign o_s_data = own_data;

    // Responses go only to the owner; acks seen while idle fall on the floor.
    always_comb begin
        rsp0.ack   = i_s_ack & grant0 & ~fire;
        rsp0.err   = fire & grant0;
        rsp0.stall = ~grant0 | i_s_stall | sat;
        rsp1.ack   = i_s_ack & grant1 & ~fire;
        rsp1.err   = fire & grant1;
        rsp1.stall = ~grant1 | i_s_stall | sat;
    end

    assign o_m0_ack   = rsp0.ack;
    assign o_m0_err   = rsp0.err;
    assign o_m0_stall = rsp0.stall;
    assign o_m0_data  = i_s_data;
    assign o_m1_ack   = rsp1.ack;
    assign o_m1_err   = rsp1.err;
    assign o_m1_stall = rsp1.stall;
    assign o_m1_data  = i_s_data;

    // Owner letting go of cyc ends the cycle; anything still in flight is abandoned.
    assign abort    = (state != ARB_IDLE) & ~own_cyc;
    assign s_take   = o_s_stb & ~i_s_stall;
    assign ack_take = i_s_ack & (count != '0);

    // Next grant: round-robin from IDLE, locked to the owner until it drops cyc or times out.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            ARB_IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    last_nxt  = tie_winner(last);
                    state_nxt = tie_winner(last) ? ARB_GNT1 : ARB_GNT0;
                end else if (i_m0_cyc) begin
                    last_nxt  = 1'b0;
                    state_nxt = ARB_GNT0;
                end else if (i_m1_cyc) begin
                    last_nxt  = 1'b1;
                    state_nxt = ARB_GNT1;
                end
            end
            ARB_GNT0: if (!i_m0_cyc || fire) state_nxt = ARB_IDLE;
            ARB_GNT1: if (!i_m1_cyc || fire) state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // Outstanding transfers: up on an accepted strobe, down on an ack, wiped when the cycle ends.
    always_comb begin
        count_nxt = count;
        if ((state == ARB_IDLE) || abort || fire) begin
            count_nxt = '0;
        end else begin
            case ({s_take, ack_take})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Grant state, round-robin pointer and outstanding count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ARB_IDLE;
            last  <= 1'b1;
            count <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            count <= count_nxt;
        end
    end

    assign wd_busy = (count != '0);
    assign wd_clr  = abort | (state == ARB_IDLE);

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .busy    (wd_busy),
        .ack     (i_s_ack),
        .clr     (wd_clr),
        .fire    (fire)
    );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Randomized bench for wb_arbiter2 with a transaction-level reference model and scoreboard.
// Latency: expected outputs for each cycle are queued at drive time and checked mid-cycle.
// Backpressure: random slave stall, slow/hung acks, spurious acks, aborts and a mid-run reset.
module tb_wb_arbiter2;

    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 16;
    localparam int NCYC    = 3000;
    localparam int CMAX    = (1 << CNT_W) - 1;

    typedef struct {
        bit        s_cyc;
        bit        s_stb;
        bit        s_we;
        bit        fire;
        bit [31:0] s_addr;
        bit [31:0] s_data;
        bit [31:0] mdata;
        bit [1:0]  ack;
        bit [1:0]  err;
        bit [1:0]  stall;
    } exp_t;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b1;
    logic [1:0]  m_cyc   = '0;
    logic [1:0]  m_stb   = '0;
    logic [1:0]  m_we    = '0;
    logic [31:0] m_addr [2];
    logic [31:0] m_wdat [2];
    logic        s_ack   = 1'b0;
    logic        s_stall = 1'b0;
    logic [31:0] s_rdata = 32'h0;

    logic [1:0]  o_ack, o_err, o_stall;
    logic [31:0] o_mdat [2];
    logic        o_s_cyc, o_s_stb, o_s_we;
    logic [31:0] o_s_addr, o_s_data;

    wb_arbiter2 #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_m0_cyc   (m_cyc[0]),
        .i_m0_stb   (m_stb[0]),
        .i_m0_we    (m_we[0]),
        .i_m0_addr  (m_addr[0]),
        .i_m0_data  (m_wdat[0]),
        .o_m0_ack   (o_ack[0]),
        .o_m0_err   (o_err[0]),
        .o_m0_stall (o_stall[0]),
        .o_m0_data  (o_mdat[0]),
        .i_m1_cyc   (m_cyc[1]),
        .i_m1_stb   (m_stb[1]),
        .i_m1_we    (m_we[1]),
        .i_m1_addr  (m_addr[1]),
        .i_m1_data  (m_wdat[1]),
        .o_m1_ack   (o_ack[1]),
        .o_m1_err   (o_err[1]),
        .o_m1_stall (o_stall[1]),
        .o_m1_data  (o_mdat[1]),
        .o_s_cyc    (o_s_cyc),
        .o_s_stb    (o_s_stb),
        .o_s_we     (o_s_we),
        .o_s_addr   (o_s_addr),
        .o_s_data   (o_s_data),
        .i_s_ack    (s_ack),
        .i_s_stall  (s_stall),
        .i_s_data   (s_rdata)
    );

    initial forever #5 i_clk = ~i_clk;

    // Reference model: owner (-1 = nobody), last winner, transfers in flight, quiet cycles.
    int mown   = -1;
    int mlast  = 1;
    int mcnt   = 0;
    int mquiet = 0;

    // Master and slave behaviour state.
    int burst [2];
    int waitk [2];
    int age   [2];
    int spend = 0;
    int hang  = 0;
    int rst_hold = 0;
    bit did_mid_reset = 1'b0;

    exp_t expq [$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   fires_seen = 0;

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, req);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    // Expected outputs for the current cycle from the model state and the inputs now driven.
    function automatic exp_t predict();
        exp_t e;
        bit   ocyc, ostb, sat, fire;
        int   o;
        o    = mown;
        ocyc = (o >= 0) ? m_cyc[o[0]] : 1'b0;
        ostb = (o >= 0) ? m_stb[o[0]] : 1'b0;
        sat  = (mcnt == CMAX);
        fire = (mcnt > 0) && !s_ack && (mquiet == TIMEOUT - 1);
        e.fire   = fire;
        e.s_cyc  = ocyc && !fire;
        e.s_stb  = e.s_cyc && ostb && !sat;
        e.s_we   = (o >= 0) ? m_we[o[0]]   : 1'b0;
        e.s_addr = (o >= 0) ? m_addr[o[0]] : 32'h0;
        e.s_data = (o >= 0) ? m_wdat[o[0]] : 32'h0;
        e.mdata  = s_rdata;
        for (int m = 0; m < 2; m++) begin
            e.stall[m] = (o != m) || s_stall || sat;
            e.ack[m]   = s_ack && (o == m) && !fire;
            e.err[m]   = fire && (o == m);
        end
        return e;
    endfunction

    task automatic model_reset();
        mown   = -1;
        mlast  = 1;
        mcnt   = 0;
        mquiet = 0;
    endtask

    // Apply the clock edge that just happened to the model, using the cycle's inputs.
    task automatic model_step();
        bit acc, dec;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        acc = cur.s_stb && !s_stall;
        dec = s_ack && (mcnt > 0);
        if (cur.fire) fires_seen++;
        if (mown < 0) begin
            if (m_cyc[0] && m_cyc[1]) mown = (mlast == 0) ? 1 : 0;
            else if (m_cyc[0])        mown = 0;
            else if (m_cyc[1])        mown = 1;
            if (mown >= 0) mlast = mown;
        end else if (cur.fire || !m_cyc[mown[0]]) begin
            mown   = -1;
            mcnt   = 0;
            mquiet = 0;
        end else begin
            mquiet = (mcnt > 0 && !s_ack) ? mquiet + 1 : 0;
            mcnt   = mcnt + int'(acc) - int'(dec);
        end
    endtask

    task automatic new_req(input int m);
        m_we[m]   = 1'($urandom_range(0, 1));
        m_addr[m] = 32'h2000_0000 | ($urandom & 32'h0000_00FC);
        m_wdat[m] = $urandom;
    endtask

    task automatic start_txn(input int m);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        burst[m] = $urandom_range(1, 5);
        waitk[m] = 0;
        age[m]   = 0;
        new_req(m);
    endtask

    task automatic drop_txn(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        burst[m] = 0;
        waitk[m] = 0;
    endtask

    // Masters: hold a request until accepted, wait for their acks, sometimes abort.
    task automatic bfm_step();
        for (int m = 0; m < 2; m++) begin
            bit accepted;
            accepted = 1'b0;
            if (!i_rst_n) begin
                drop_txn(m);
            end else if (m_cyc[m]) begin
                age[m]++;
                if (m_stb[m] && !cur.stall[m]) begin
                    burst[m]--;
                    waitk[m]++;
                    accepted = 1'b1;
                end
                if (cur.ack[m] && waitk[m] > 0) waitk[m]--;
                if (cur.err[m] || (burst[m] == 0 && waitk[m] == 0) || age[m] > 80 ||
                    $urandom_range(0, 59) == 0) begin
                    drop_txn(m);
                end else begin
                    m_stb[m] = (burst[m] > 0);
                    if (accepted && burst[m] > 0) new_req(m);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                start_txn(m);
            end
        end
    endtask

    // Slave: random stall, acks in order with random delay, occasional hangs and stray acks.
    task automatic slave_step();
        if (cur.s_stb && !s_stall) spend++;
        if (s_ack && spend > 0) spend--;
        if (hang > 0) hang--;
        else if ($urandom_range(0, 79) == 0) hang = 24;
        s_stall = ($urandom_range(0, 3) == 0);
        s_ack   = ((spend > 0) && (hang == 0) && ($urandom_range(0, 2) != 0)) ||
                  ($urandom_range(0, 49) == 0);
        s_rdata = $urandom;
    endtask

    // Monitor: compare every output against the expectation queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk1("s_cyc", o_s_cyc, e.s_cyc);
                chk1("s_stb", o_s_stb, e.s_stb);
                chk1("s_we", o_s_we, e.s_we);
                chk32("s_addr", o_s_addr, e.s_addr);
                chk32("s_data", o_s_data, e.s_data);
                for (int m = 0; m < 2; m++) begin
                    chk1($sformatf("m%0d_ack", m), o_ack[m], e.ack[m]);
                    chk1($sformatf("m%0d_err", m), o_err[m], e.err[m]);
                    chk1($sformatf("m%0d_stall", m), o_stall[m], e.stall[m]);
                    chk32($sformatf("m%0d_data", m), o_mdat[m], e.mdata);
                end
            end
        end
    end

    // Driver: advance model and stimulus just after each edge, then queue the expectation.
    initial begin
        for (int m = 0; m < 2; m++) begin
            m_addr[m] = 32'h0;
            m_wdat[m] = 32'h0;
            burst[m]  = 0;
            waitk[m]  = 0;
            age[m]    = 0;
        end
        #1;
        i_rst_n  = 1'b0;
        rst_hold = 4;
        cur      = predict();
        for (int c = 0; c < NCYC; c++) begin
            @(posedge i_clk);
            #1;
            model_step();
            slave_step();
            bfm_step();
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) begin
                    i_rst_n = 1'b1;
                    start_txn(0);
                    start_txn(1);
                end
            end else if (!did_mid_reset && c >= 1500 &&
                         ((mown == 0 && mcnt >= 2) || c >= 2500)) begin
                did_mid_reset = 1'b1;
                i_rst_n  = 1'b0;
                rst_hold = 3;
                model_reset();
                drop_txn(0);
                drop_txn(1);
                spend = 0;
                hang  = 0;
            end
            cur = predict();
            expq.push_back(cur);
        end
        @(negedge i_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
